// File: rtl/gpio_mmio_bank_if.sv
// Data-memory side bus of the GPIO register bank: chip select, word address,
// byte enables, write data, write strobe and registered read data.
interface gpio_mmio_bank_if;
  // Access semantics: no valid/ready pair and no back-pressure. With cs=1 the bank
  // accepts a write (wren=1) or a read (wren=0) on every rising edge. A read's q is
  // valid one cycle later and then holds until the next read.
  logic        cs;
  logic [5:0]  address;
  logic [3:0]  byteena;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q;

  modport master (output cs, address, byteena, data, wren, input q);
  modport slave  (input cs, address, byteena, data, wren, output q);
endinterface

// File: rtl/gpio_mmio_bank.sv
// Memory-mapped GPIO bank: N_OUT output registers, N_IN synchronised input channels,
// change-capture STATUS (W1C), MASK and irq. Optional debounce with GPIO_DEBOUNCE_EN.
module gpio_mmio_bank #(
  parameter int N_OUT           = 7,
  parameter int OUT_W           = 10,
  parameter int N_IN            = 5,
  parameter int IN_W            = 10,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  gpio_mmio_bank_if.slave         bus,
  input  logic [N_IN*IN_W-1:0]    io_input_bus,
  output logic [N_OUT*OUT_W-1:0]  io_output_bus,
  output logic                    irq
);

  localparam logic [5:0] ADDR_STATUS = 6'h20;
  localparam logic [5:0] ADDR_MASK   = 6'h21;

  if (N_OUT < 1 || N_OUT > 16 || OUT_W < 1 || OUT_W > 32 ||
      N_IN < 1 || N_IN > 16 || IN_W < 1 || IN_W > 32 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
    $error("gpio_mmio_bank: parameter out of range");
  end

  logic [OUT_W-1:0]       out_reg [N_OUT];
  logic [N_IN*IN_W-1:0]   sync1;
  logic [N_IN*IN_W-1:0]   sync2;
  logic [N_IN*IN_W-1:0]   cond;
  logic [N_IN*IN_W-1:0]   cond_d;
  logic [N_IN-1:0]        status;
  logic [N_IN-1:0]        mask;
  logic [N_IN-1:0]        status_set;
  logic [N_IN-1:0]        status_clr;
  logic [N_IN-1:0]        status_nxt;
  logic [N_IN-1:0]        mask_nxt;
  logic [N_IN-1:0]        lane_mask;
  logic [31:0]            rdata;
  logic                   wr;

  function automatic logic [31:0] merge_be(input logic [31:0] cur,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = cur;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) r[8*k +: 8] = wdata[8*k +: 8];
    end
    return r;
  endfunction

  assign wr  = bus.cs & bus.wren;
  assign irq = |(status & mask);

  always_comb begin
    io_output_bus = '0;
    for (int i = 0; i < N_OUT; i++) begin
      io_output_bus[i*OUT_W +: OUT_W] = out_reg[i];
    end
  end

  // STATUS/MASK bits live in byte lane (bit / 8) for byte-enable gating.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < N_IN; i++) begin
      lane_mask[i] = bus.byteena[i >> 3];
    end
  end

  always_comb begin
    status_set = '0;
    for (int i = 0; i < N_IN; i++) begin
      status_set[i] = (cond[i*IN_W +: IN_W] != cond_d[i*IN_W +: IN_W]);
    end
    status_clr = '0;
    if (wr && bus.address == ADDR_STATUS) status_clr = bus.data[N_IN-1:0] & lane_mask;
    // Set is applied after clear so a same-cycle change keeps the bit high.
    status_nxt = (status & ~status_clr) | status_set;
    mask_nxt   = (mask & ~lane_mask) | (bus.data[N_IN-1:0] & lane_mask);
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (bus.address == 6'(i)) rdata = 32'(out_reg[i]);
    end
    for (int i = 0; i < N_IN; i++) begin
      if (bus.address == 6'(16 + i)) rdata = 32'(cond[i*IN_W +: IN_W]);
    end
    if (bus.address == ADDR_STATUS) rdata = 32'(status);
    if (bus.address == ADDR_MASK)   rdata = 32'(mask);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < N_OUT; i++) out_reg[i] <= '0;
      sync1  <= '0;
      sync2  <= '0;
      cond_d <= '0;
      status <= '0;
      mask   <= '0;
      bus.q  <= '0;
    end else begin
      sync1  <= io_input_bus;
      sync2  <= sync1;
      cond_d <= cond;
      status <= status_nxt;
      for (int i = 0; i < N_OUT; i++) begin
        if (wr && bus.address == 6'(i))
          out_reg[i] <= OUT_W'(merge_be(32'(out_reg[i]), bus.data, bus.byteena));
      end
      if (wr && bus.address == ADDR_MASK) mask <= mask_nxt;
      if (bus.cs && !bus.wren) bus.q <= rdata;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] deb_cnt [N_IN];

  // The conditioned value follows the synchroniser only after DEBOUNCE_CYCLES
  // consecutive cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cond <= '0;
      for (int i = 0; i < N_IN; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (sync2[i*IN_W +: IN_W] == cond[i*IN_W +: IN_W]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          cond[i*IN_W +: IN_W] <= sync2[i*IN_W +: IN_W];
          deb_cnt[i]           <= '0;
        end else if (deb_cnt[i] != CNT_W'(DEBOUNCE_CYCLES)) begin
          deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  assign cond = sync2;
`endif

endmodule

// File: tb/tb_gpio_mmio_bank.sv
// Directed self-checking bench for gpio_mmio_bank; read results flow through an
// expected-value queue. Debounce vectors are built when GPIO_DEBOUNCE_EN is defined.
module tb_gpio_mmio_bank;
  localparam int N_OUT = 7;
  localparam int OUT_W = 10;
  localparam int N_IN  = 5;
  localparam int IN_W  = 10;
  localparam int DEB   = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int COND_LAT = 2 + DEB;
`else
  localparam int COND_LAT = 2;
`endif

  logic                   clock = 1'b0;
  logic                   reset_n;
  logic [N_IN*IN_W-1:0]   io_input_bus;
  logic [N_OUT*OUT_W-1:0] io_output_bus;
  logic                   irq;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  gpio_mmio_bank_if bus ();

  gpio_mmio_bank #(
    .N_OUT(N_OUT), .OUT_W(OUT_W), .N_IN(N_IN), .IN_W(IN_W), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus),
    .io_input_bus(io_input_bus),
    .io_output_bus(io_output_bus),
    .irq(irq)
  );

  // Clock and reset
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic bus_idle();
    bus.cs      = 1'b0;
    bus.wren    = 1'b0;
    bus.address = '0;
    bus.byteena = '0;
    bus.data    = '0;
  endtask

  task automatic bus_write(input logic [5:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    bus.cs      = 1'b1;
    bus.wren    = 1'b1;
    bus.address = addr;
    bus.data    = wdata;
    bus.byteena = be;
    tick();
    bus_idle();
  endtask

  task automatic read_expect(input string tag, input logic [5:0] addr, input logic [31:0] exp);
    exp_q.push_back(exp);
    bus.cs      = 1'b1;
    bus.wren    = 1'b0;
    bus.address = addr;
    tick();
    bus_idle();
    check(tag, bus.q, exp_q.pop_front());
  endtask

  task automatic set_chan(input int ch, input logic [IN_W-1:0] val);
    io_input_bus[ch*IN_W +: IN_W] = val;
  endtask

  initial begin
    bus_idle();
    io_input_bus = '0;
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;

    // Reset state
    check("rst_q", bus.q, 32'h0);
    check("rst_out_bus", 32'(|io_output_bus), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    read_expect("rst_out0", 6'h00, 32'h0);
    read_expect("rst_in0", 6'h10, 32'h0);
    read_expect("rst_status", 6'h20, 32'h0);
    read_expect("rst_mask", 6'h21, 32'h0);

    // Byte-lane writes and readback
    bus_write(6'h02, 32'hFFFF_FFFF, 4'b0001);
    check("out2_lane0", 32'(io_output_bus[29:20]), 32'h0FF);
    bus_write(6'h02, 32'hFFFF_FFFF, 4'b0010);
    check("out2_lane1", 32'(io_output_bus[29:20]), 32'h3FF);
    read_expect("out2_rb", 6'h02, 32'h3FF);
    bus.address = 6'h00;
    tick();
    check("q_hold", bus.q, 32'h3FF);
    bus_write(6'h06, 32'h1234_5678, 4'b1111);
    check("out6_bus", 32'(io_output_bus[69:60]), 32'h278);
    read_expect("out6_rb", 6'h06, 32'h278);
    read_expect("unmapped_3f", 6'h3F, 32'h0);
    bus_write(6'h07, 32'hFFFF_FFFF, 4'b1111);
    bus_write(6'h11, 32'hFFFF_FFFF, 4'b1111);
    read_expect("in1_write_ignored", 6'h11, 32'h0);
    read_expect("out7_unmapped", 6'h07, 32'h0);
    read_expect("out5_untouched", 6'h05, 32'h0);

    // Input path, STATUS capture, MASK and irq
    set_chan(1, 10'h155);
    repeat (COND_LAT - 1) tick();
    read_expect("in1_early", 6'h11, 32'h0);
    read_expect("in1", 6'h11, 32'h155);
    read_expect("status_ch1", 6'h20, 32'h02);
    check("irq_masked", 32'(irq), 32'h0);
    bus_write(6'h21, 32'h02, 4'b0001);
    check("irq_on", 32'(irq), 32'h1);
    read_expect("mask_rb", 6'h21, 32'h02);
    bus_write(6'h20, 32'h02, 4'b0001);
    check("irq_off", 32'(irq), 32'h0);
    read_expect("status_cleared", 6'h20, 32'h0);

    // Same-cycle set and W1C: set wins
    set_chan(3, 10'h2AA);
    repeat (COND_LAT) tick();
    bus_write(6'h20, 32'h08, 4'b0001);
    read_expect("status_set_wins", 6'h20, 32'h08);
    check("irq_mask_filters", 32'(irq), 32'h0);
    bus_write(6'h20, 32'h08, 4'b0001);
    read_expect("status3_cleared", 6'h20, 32'h0);

    // W1C gated by byte enable
    set_chan(4, 10'h001);
    repeat (COND_LAT + 1) tick();
    read_expect("status_ch4", 6'h20, 32'h10);
    bus_write(6'h20, 32'h10, 4'b0010);
    read_expect("w1c_wrong_lane", 6'h20, 32'h10);
    bus_write(6'h20, 32'h10, 4'b0001);
    read_expect("w1c_lane0", 6'h20, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
    // Short glitch is rejected, a held level is accepted
    set_chan(0, 10'h001);
    repeat (3) tick();
    set_chan(0, 10'h000);
    repeat (10) tick();
    read_expect("deb_glitch_in0", 6'h10, 32'h0);
    read_expect("deb_glitch_status", 6'h20, 32'h0);
    set_chan(0, 10'h001);
    repeat (6) tick();
    read_expect("deb_held_in0", 6'h10, 32'h1);
`endif

    // Reset during a write discards it
    read_expect("pre_reset_out2", 6'h02, 32'h3FF);
    bus.cs      = 1'b1;
    bus.wren    = 1'b1;
    bus.address = 6'h00;
    bus.data    = 32'h0000_03FF;
    bus.byteena = 4'b1111;
    reset_n     = 1'b0;
    tick();
    bus_idle();
    reset_n = 1'b1;
    check("rst_mid_out0", 32'(io_output_bus[9:0]), 32'h0);
    check("rst_mid_out2", 32'(io_output_bus[29:20]), 32'h0);
    check("rst_mid_q", bus.q, 32'h0);
    check("rst_mid_irq", 32'(irq), 32'h0);
    read_expect("rst_mid_out0_rb", 6'h00, 32'h0);
    read_expect("rst_mid_mask", 6'h21, 32'h0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
